load_store_unit: RTL and testbench

- MEM-stage front end that sits directly upstream of the word-addressed data memory, between the EX/MEM pipeline register and the memory.
- Translates RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sub-word stores become a two-cycle read-modify-write, because the memory has no byte enables.
- Loads are sign/zero-extended; misaligned, illegal and out-of-range accesses are flagged and never reach the memory.

---
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end for a word-addressed memory without byte enables.
// Sub-word stores are done as read (IDLE) then write of the merged word (MERGE).
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 2048
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  misaligned,
  output logic                  access_fault,
  output logic                  mem_rd,
  output logic                  mem_wrt,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [0:0] {IDLE, MERGE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  mis_q, mis_d;
  logic                  fault_q, fault_d;

  logic [ADDR_WIDTH-3:0] widx;
  logic                  any_req, oob, illegal, unaligned;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           load_ext, merged;

  assign widx     = addr[ADDR_WIDTH-1:2];
  assign mem_addr = 32'(widx);
  assign oob      = 64'(widx) >= 64'(MEM_WORDS);
  assign any_req  = req_load | req_store;

  always_comb begin
    illegal = 1'b0;
    if (req_load && req_store)
      illegal = 1'b1;
    else if (req_load)
      illegal = !(funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else if (req_store)
      illegal = !(funct3 inside {3'd0, 3'd1, 3'd2});
    if (any_req && oob)
      illegal = 1'b1;
    unaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  end

  always_comb begin
    lane_b = mem_rdata[{addr[1:0], 3'b000} +: 8];
    lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_ext = {24'b0, lane_b};
      3'd5:    load_ext = {16'b0, lane_h};
      default: load_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3[1:0] == 2'b00)
      merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    else
      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mis_d     = 1'b0;
    fault_d   = 1'b0;
    mem_rd    = 1'b0;
    mem_wrt   = 1'b0;
    stall     = 1'b0;
    mem_wdata = wdata;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (illegal) begin
            fault_d = 1'b1;
          end else if (unaligned) begin
            mis_d = 1'b1;
          end else if (req_load) begin
            mem_rd   = 1'b1;
            rvalid_d = 1'b1;
            rdata_d  = load_ext;
          end else if (funct3[1:0] == 2'b10) begin
            mem_wrt = 1'b1;
          end else begin
            mem_rd  = 1'b1;
            stall   = 1'b1;
            buf_d   = merged;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        // Held request is consumed here, not re-decoded.
        mem_wrt   = 1'b1;
        mem_wdata = buf_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes drop the moment reset asserts so an in-flight merge never writes.
    if (!rst_) begin
      mem_rd  = 1'b0;
      mem_wrt = 1'b0;
      stall   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      mis_q    <= mis_d;
      fault_q  <= fault_d;
    end
  end

  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign misaligned   = mis_q;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a negedge-write word memory attached.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_;
  logic        req_load, req_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rvalid, misaligned, access_fault, mem_rd, mem_wrt;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:2047];
  logic        pre_we = 1'b0;
  logic [10:0] pre_idx;
  logic [31:0] pre_dat;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .MEM_WORDS(2048)) dut (
    .clk(clk), .rst_(rst_), .req_load(req_load), .req_store(req_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .rvalid(rvalid), .misaligned(misaligned),
    .access_fault(access_fault), .mem_rd(mem_rd), .mem_wrt(mem_wrt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(negedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else if (mem_wrt) mem[mem_addr[10:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[10:0]];

  always @(negedge clk) if (stall) stall_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic s, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] w);
    req_load = l; req_store = s; funct3 = f; addr = a; wdata = w;
    #1;
  endtask

  task automatic preload(input logic [10:0] idx, input logic [31:0] dat);
    pre_idx = idx; pre_dat = dat; pre_we = 1'b1;
    @(negedge clk);
    #1;
    pre_we = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    drive(0, 0, 3'd0, 32'h0, 32'h0);
    checks++;
    if ({rvalid, misaligned, access_fault, stall, mem_rd, mem_wrt} !== 6'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b rdata=%h expected flags=000000 rdata=00000000",
               {rvalid, misaligned, access_fault, stall, mem_rd, mem_wrt}, rdata);
    end
    tick();
    rst_ = 1'b1;
    preload(11'd24, 32'h11223344);
    drive(0, 1, 3'd0, 32'h60, 32'hAA);
    tick();
    checks++;
    if (mem_wrt !== 1'b1 || mem_wdata !== 32'h112233AA) begin
      errors++;
      $display("FAIL reset_merge_setup: mem_wrt=%b wdata=%h expected 1 112233aa", mem_wrt, mem_wdata);
    end
    rst_ = 1'b0;
    #1;
    checks++;
    if ({mem_wrt, mem_rd, stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_abort_strobes: wrt/rd/stall=%b expected 000", {mem_wrt, mem_rd, stall});
    end
    drive(0, 0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checks++;
    if (mem[24] !== 32'h11223344) begin
      errors++;
      $display("FAIL reset_no_partial_write: mem=%h expected 11223344", mem[24]);
    end
    tick();
    rst_ = 1'b1;
    #1;
    checks++;
    if ({rvalid, misaligned, access_fault, stall, mem_rd, mem_wrt} !== 6'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_after_abort: flags=%b rdata=%h expected 000000 00000000",
               {rvalid, misaligned, access_fault, stall, mem_rd, mem_wrt}, rdata);
    end
    drive(1, 0, 3'd2, 32'h60, 32'h0);
    checks++;
    if (mem_rd !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_state: mem_rd=%b stall=%b expected 1 0", mem_rd, stall);
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL reset_word_intact: rvalid=%b rdata=%h expected 1 11223344", rvalid, rdata);
    end
    drive(0, 0, 3'd0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_word_roundtrip;
    int s0 = stall_cnt;
    drive(0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    checks++;
    if ({mem_wrt, mem_rd, stall} !== 3'b100 || mem_addr !== 32'd4 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_strobes: wrt/rd/stall=%b addr=%h wdata=%h expected 100 4 deadbeef",
               {mem_wrt, mem_rd, stall}, mem_addr, mem_wdata);
    end
    tick();
    drive(1, 0, 3'd2, 32'h10, 32'h0);
    checks++;
    if ({mem_wrt, mem_rd, stall} !== 3'b010 || mem_addr !== 32'd4 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL lw_strobes: wrt/rd/stall=%b addr=%h rvalid=%b expected 010 4 0",
               {mem_wrt, mem_rd, stall}, mem_addr, rvalid);
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_data: rvalid=%b rdata=%h expected 1 deadbeef", rvalid, rdata);
    end
    drive(0, 0, 3'd0, 32'h0, 32'h0);
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'hDEADBEEF || stall_cnt != s0) begin
      errors++;
      $display("FAIL lw_hold: rvalid=%b rdata=%h stalls=%0d expected 0 deadbeef 0",
               rvalid, rdata, stall_cnt - s0);
    end
  endtask

  task automatic test_sign_ext;
    logic [2:0]  f [5] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] a [5] = '{32'h21, 32'h22, 32'h23, 32'h22, 32'h22};
    logic [31:0] e [5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    preload(11'd8, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, f[i], a[i], 32'h0);
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== e[i]) begin
        errors++;
        $display("FAIL sign_ext[%0d] f3=%0d addr=%h: rvalid=%b rdata=%h expected 1 %h",
                 i, f[i], a[i], rvalid, rdata, e[i]);
      end
    end
    drive(0, 0, 3'd0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_subword_store;
    int s0;
    preload(11'd12, 32'h11223344);
    s0 = stall_cnt;
    drive(0, 1, 3'd0, 32'h31, 32'hAA);
    checks++;
    if ({mem_wrt, mem_rd, stall} !== 3'b011) begin
      errors++;
      $display("FAIL sb_read_phase: wrt/rd/stall=%b expected 011", {mem_wrt, mem_rd, stall});
    end
    tick();
    checks++;
    if ({mem_wrt, mem_rd, stall} !== 3'b100 || mem_wdata !== 32'h1122AA44) begin
      errors++;
      $display("FAIL sb_merge: wrt/rd/stall=%b wdata=%h expected 100 1122aa44",
               {mem_wrt, mem_rd, stall}, mem_wdata);
    end
    tick();
    drive(0, 1, 3'd1, 32'h32, 32'hBEEF);
    tick();
    checks++;
    if (mem_wrt !== 1'b1 || mem_wdata !== 32'hBEEFAA44) begin
      errors++;
      $display("FAIL sh_merge: wrt=%b wdata=%h expected 1 beefaa44", mem_wrt, mem_wdata);
    end
    tick();
    drive(0, 0, 3'd0, 32'h0, 32'h0);
    checks++;
    if (mem[12] !== 32'hBEEFAA44 || stall_cnt - s0 != 2) begin
      errors++;
      $display("FAIL subword_result: mem=%h stalls=%0d expected beefaa44 2", mem[12], stall_cnt - s0);
    end
  endtask

  task automatic test_faults;
    logic        l [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        s [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f [7] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd2, 3'd3, 3'd4};
    logic [31:0] a [7] = '{32'h41, 32'h43, 32'h40, 32'h2000, 32'h40, 32'h41, 32'h40};
    logic [1:0]  e [7] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 7; i++) begin
      drive(l[i], s[i], f[i], a[i], 32'h12345678);
      checks++;
      if ({mem_wrt, mem_rd, stall} !== 3'b000) begin
        errors++;
        $display("FAIL fault_strobes[%0d]: wrt/rd/stall=%b expected 000", i, {mem_wrt, mem_rd, stall});
      end
      tick();
      checks++;
      if ({misaligned, access_fault} !== e[i] || rvalid !== 1'b0) begin
        errors++;
        $display("FAIL fault_flags[%0d]: mis/fault=%b rvalid=%b expected %b 0",
                 i, {misaligned, access_fault}, rvalid, e[i]);
      end
    end
    drive(1, 0, 3'd2, 32'h1FFC, 32'h0);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h7FF) begin
      errors++;
      $display("FAIL last_word_legal: mem_rd=%b addr=%h expected 1 7ff", mem_rd, mem_addr);
    end
    tick();
    drive(0, 0, 3'd0, 32'h0, 32'h0);
    checks++;
    if ({misaligned, access_fault, rvalid} !== 3'b001) begin
      errors++;
      $display("FAIL last_word_flags: mis/fault/rvalid=%b expected 001", {misaligned, access_fault, rvalid});
    end
    tick();
    checks++;
    if ({misaligned, access_fault, rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL pulse_clear: mis/fault/rvalid=%b expected 000", {misaligned, access_fault, rvalid});
    end
  endtask

  task automatic test_back_to_back;
    int s0;
    preload(11'd20, 32'h01020304);
    s0 = stall_cnt;
    drive(0, 1, 3'd0, 32'h50, 32'h55);
    tick();
    checks++;
    if (mem_wrt !== 1'b1 || mem_wdata !== 32'h01020355) begin
      errors++;
      $display("FAIL b2b_merge: wrt=%b wdata=%h expected 1 01020355", mem_wrt, mem_wdata);
    end
    tick();
    drive(1, 0, 3'd2, 32'h50, 32'h0);
    checks++;
    if ({mem_wrt, mem_rd, stall} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_lw_strobes: wrt/rd/stall=%b expected 010", {mem_wrt, mem_rd, stall});
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h01020355) begin
      errors++;
      $display("FAIL b2b_lw_data: rvalid=%b rdata=%h expected 1 01020355", rvalid, rdata);
    end
    drive(0, 1, 3'd2, 32'h54, 32'hCAFEF00D);
    checks++;
    if ({mem_wrt, mem_rd, stall} !== 3'b100 || mem_wdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_sw: wrt/rd/stall=%b wdata=%h expected 100 cafef00d",
               {mem_wrt, mem_rd, stall}, mem_wdata);
    end
    tick();
    drive(0, 0, 3'd0, 32'h0, 32'h0);
    checks++;
    if (mem[21] !== 32'hCAFEF00D || rvalid !== 1'b0 || stall_cnt - s0 != 1) begin
      errors++;
      $display("FAIL b2b_result: mem=%h rvalid=%b stalls=%0d expected cafef00d 0 1",
               mem[21], rvalid, stall_cnt - s0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_roundtrip();
    test_sign_ext();
    test_subword_store();
    test_faults();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
